dual_clcg_sequencer: RTL and testbench
======================================

Name: dual_clcg_sequencer

Overview:
- Multi-cycle controller for the modified dual-CLCG core. It time-shares one shift unit and one adder between two LCG state registers, x and y.
- Each iteration computes x' = x + (x<<r1) + b1 mod 2^N and y' = y + (y<<r2) + b2 mod 2^N, then emits bit z = (x' > y').
- It sits between the seed/configuration interface and the random-bit consumer. Output uses a valid/ready handshake.

Parameters:
- N, 16, LCG state width in bits.
- RW, 4, width of the shift-amount fields r1/r2; must satisfy 2^RW >= N.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- seed_load  in  1  load seeds and configuration; acted on only in IDLE.
- x_seed  in  N  initial x.
- y_seed  in  N  initial y.
- b1  in  N  x increment.
- b2  in  N  y increment.
- r1  in  RW  x shift amount; multiplier a1 = 1+2^r1.
- r2  in  RW  y shift amount; multiplier a2 = 1+2^r2.
- start  in  1  request one iteration; level-sensitive.
- out_ready  in  1  consumer accepts out_bit.
- out_valid  out  1  out_bit is valid.
- out_bit  out  1  generated random bit.
- busy  out  1  high whenever state != IDLE.
- cfg_err  out  1  latched configuration is not full-period.
- x_state  out  N  current x register.
- y_state  out  N  current y register.

Behaviour:
- Reset (asynchronous): state=IDLE. x, y, tmp, b1/b2/r1/r2 shadow registers all 0. out_valid=0, out_bit=0, cfg_err=0. rst mid-iteration aborts immediately; no partial update survives.
- FSM states: IDLE, XS, XA, YS, YA, CMP, OUT.
- IDLE:
  - seed_load=1: latch x_seed, y_seed, b1, b2, r1, r2 into shadow registers; stay IDLE.
  - seed_load=1 and start=1 in the same cycle: load wins, start ignored that cycle.
  - start=1 and seed_load=0: go to XS.
- XS: tmp <= (x << r1) truncated to N bits; go to XA.
- XA: x <= x + tmp + b1, mod 2^N (carry discarded); go to YS.
- YS: tmp <= (y << r2) truncated to N bits; go to YA.
- YA: y <= y + tmp + b2, mod 2^N; go to CMP.
- CMP: out_bit <= (x > y), unsigned compare on the updated values; out_valid <= 1; go to OUT.
- OUT: hold out_valid=1; out_bit is stable.
  - out_ready=1 and start=1: out_valid <= 0; go to XS (back-to-back iteration).
  - out_ready=1 and start=0: out_valid <= 0; go to IDLE.
  - out_ready=0: stay in OUT indefinitely.
- Latency: start sampled in IDLE at edge k, out_valid high after edge k+5.
- Throughput: sustained rate 1 bit per 6 cycles with start=1 and out_ready=1.
- A shift amount r >= N yields tmp=0.
- seed_load outside IDLE is ignored; shadow registers are unchanged.
- cfg_err is updated on every accepted seed_load. It is set high if r1<2, r2<2, b1[0]==0 or b2[0]==0; otherwise cleared. It is advisory only; the sequencer still runs.
- x_state and y_state reflect the registers directly, with no extra latency.

Decomposition:
- Package clcg_pkg holds:
  - the FSM state enum: IDLE, XS, XA, YS, YA, CMP, OUT;
  - a localparam for the minimum full-period shift (2);
  - a function computing the cfg_err predicate.
- One natural sub-module: clcg_shift_add. It holds the shared tmp register and shift/add datapath, selected by an op/sel input from the FSM, so the two LCGs share one shifter and one adder.

Test Plan (N=8, RW=3):
- Reset mid-iteration: assert rst while in YS -> out_valid=0, busy=0, x_state=0, y_state=0 on the same cycle.
- Basic iteration: seed x=1, y=3, b1=1, b2=5, r1=2, r2=3, then start pulse -> after 5 edges x_state=6, y_state=32, out_valid=1, out_bit=0.
- Back-to-back with wrap: from the previous scenario, hold start=1 and out_ready=1 -> next iteration x=31, y=37 (y<<3=256 wraps to 0), out_bit=0, gap of 6 cycles between valid bits.
- Wrap and compare true: seed x=200, y=10, b1=b2=1, r1=r2=2 -> x=233, y=51, out_bit=1.
- Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid stays 1, out_bit stable, x/y unchanged. Releasing out_ready with start=0 -> IDLE next cycle.
- Configuration rules: seed_load with r1=1, b2=4 -> cfg_err=1. seed_load while busy -> ignored, cfg_err and shadow registers unchanged. seed_load and start together in IDLE -> loaded, busy stays 0.

Source files
------------

// File: rtl/clcg_pkg.sv
// Shared definitions for the dual-CLCG sequencer: FSM state codes, datapath
// opcodes and the full-period configuration check.
package clcg_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t XS   = 3'd1;
    localparam state_t XA   = 3'd2;
    localparam state_t YS   = 3'd3;
    localparam state_t YA   = 3'd4;
    localparam state_t CMP  = 3'd5;
    localparam state_t OUT  = 3'd6;

    typedef logic [1:0] op_t;

    localparam op_t OP_HOLD  = 2'd0;
    localparam op_t OP_SHIFT = 2'd1;
    localparam op_t OP_ADD   = 2'd2;

    // A multiplier 1+2^r reaches full period only when r >= 2.
    localparam int unsigned MIN_FULL_SHIFT = 2;

    // High when the configuration cannot give a full-period sequence.
    function automatic logic cfg_bad(
        input int unsigned ra,
        input int unsigned rb,
        input logic        b1_lsb,
        input logic        b2_lsb
    );
        return (ra < MIN_FULL_SHIFT) || (rb < MIN_FULL_SHIFT) || !b1_lsb || !b2_lsb;
    endfunction

endpackage

// File: rtl/clcg_shift_add.sv
// Shared shifter and adder for both LCGs; sel picks the x or y operand set,
// and op decides whether the shifted value is captured into tmp.
module clcg_shift_add
    import clcg_pkg::*;
#(
    parameter int N  = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  op_t           op,
    input  logic          sel,
    input  logic [N-1:0]  x,
    input  logic [N-1:0]  y,
    input  logic [N-1:0]  b1,
    input  logic [N-1:0]  b2,
    input  logic [RW-1:0] r1,
    input  logic [RW-1:0] r2,
    output logic [N-1:0]  sum
);

    logic [N-1:0]  operand;
    logic [N-1:0]  inc;
    logic [RW-1:0] amt;
    logic [N-1:0]  shifted;
    logic [N-1:0]  tmp;

    // Shift amounts at or beyond the word width push every bit out.
    always_comb begin
        operand = sel ? y  : x;
        inc     = sel ? b2 : b1;
        amt     = sel ? r2 : r1;
        if (32'(amt) >= N) begin
            shifted = '0;
        end else begin
            shifted = operand << amt;
        end
        sum = operand + tmp + inc;
    end

    // tmp is cleared once consumed so a stale product never leaks forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmp <= '0;
        end else begin
            case (op)
                OP_SHIFT: tmp <= shifted;
                OP_ADD:   tmp <= '0;
                default:  tmp <= tmp;
            endcase
        end
    end

endmodule

// File: rtl/dual_clcg_sequencer.sv
// Multi-cycle dual-CLCG controller: updates x then y through one shared
// shift/add unit and emits z = (x > y) over a valid/ready handshake.
module dual_clcg_sequencer
    import clcg_pkg::*;
#(
    parameter int N  = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          seed_load,
    input  logic [N-1:0]  x_seed,
    input  logic [N-1:0]  y_seed,
    input  logic [N-1:0]  b1,
    input  logic [N-1:0]  b2,
    input  logic [RW-1:0] r1,
    input  logic [RW-1:0] r2,
    input  logic          start,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          out_bit,
    output logic          busy,
    output logic          cfg_err,
    output logic [N-1:0]  x_state,
    output logic [N-1:0]  y_state
);

    state_t        state;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [N-1:0]  b1_q;
    logic [N-1:0]  b2_q;
    logic [RW-1:0] r1_q;
    logic [RW-1:0] r2_q;
    logic [N-1:0]  sum;
    op_t           op;
    logic          sel;

    always_comb begin
        op  = OP_HOLD;
        sel = 1'b0;
        case (state)
            XS: op = OP_SHIFT;
            XA: op = OP_ADD;
            YS: begin
                op  = OP_SHIFT;
                sel = 1'b1;
            end
            YA: begin
                op  = OP_ADD;
                sel = 1'b1;
            end
            default: ;
        endcase
    end

    clcg_shift_add #(
        .N  (N),
        .RW (RW)
    ) u_shift_add (
        .clk (clk),
        .rst (rst),
        .op  (op),
        .sel (sel),
        .x   (x),
        .y   (y),
        .b1  (b1_q),
        .b2  (b2_q),
        .r1  (r1_q),
        .r2  (r2_q),
        .sum (sum)
    );

    // Loading takes priority over start in IDLE and is ignored elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        x       <= x_seed;
                        y       <= y_seed;
                        b1_q    <= b1;
                        b2_q    <= b2;
                        r1_q    <= r1;
                        r2_q    <= r2;
                        cfg_err <= cfg_bad(32'(r1), 32'(r2), b1[0], b2[0]);
                    end else if (start) begin
                        state <= XS;
                    end
                end
                XS: state <= XA;
                XA: begin
                    x     <= sum;
                    state <= YS;
                end
                YS: state <= YA;
                YA: begin
                    y     <= sum;
                    state <= CMP;
                end
                CMP: begin
                    out_bit   <= (x > y);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= start ? XS : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign x_state = x;
    assign y_state = y;

endmodule

// File: tb/tb_dual_clcg_sequencer.sv
// Scoreboard bench for dual_clcg_sequencer (N=8, RW=3) driven by directed
// vectors with hand-computed results.
module tb_dual_clcg_sequencer;

    localparam int N  = 8;
    localparam int RW = 3;

    logic          clk;
    logic          rst;
    logic          seed_load;
    logic [N-1:0]  x_seed;
    logic [N-1:0]  y_seed;
    logic [N-1:0]  b1;
    logic [N-1:0]  b2;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic          start;
    logic          out_ready;
    logic          out_valid;
    logic          out_bit;
    logic          busy;
    logic          cfg_err;
    logic [N-1:0]  x_state;
    logic [N-1:0]  y_state;

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         b;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cycles[$];
    exp_t mon_e;
    int   checks;
    int   errors;
    int   cycle;

    dual_clcg_sequencer #(
        .N  (N),
        .RW (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .x_seed    (x_seed),
        .y_seed    (y_seed),
        .b1        (b1),
        .b2        (b2),
        .r1        (r1),
        .r2        (r2),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .x_state   (x_state),
        .y_state   (y_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic apply_seed(input logic [N-1:0] xs, input logic [N-1:0] ys,
                              input logic [N-1:0] bb1, input logic [N-1:0] bb2,
                              input logic [RW-1:0] rr1, input logic [RW-1:0] rr2,
                              input logic with_start);
        @(posedge clk);
        #1;
        seed_load = 1'b1;
        x_seed    = xs;
        y_seed    = ys;
        b1        = bb1;
        b2        = bb2;
        r1        = rr1;
        r2        = rr2;
        start     = with_start;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check_output(name, 32'(out_valid), 32'd1);
    endtask

    // Monitor: every accepted output bit is compared with the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("[TB] FAIL unexpected_output: got bit %0d x %0d y %0d, expected none",
                             out_bit, x_state, y_state);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("sb_out_bit", 32'(out_bit), 32'(mon_e.b));
                    check_output("sb_x_state", 32'(x_state), 32'(mon_e.x));
                    check_output("sb_y_state", 32'(y_state), 32'(mon_e.y));
                    pop_cycles.push_back(cycle);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        seed_load = 1'b0;
        x_seed    = '0;
        y_seed    = '0;
        b1        = '0;
        b2        = '0;
        r1        = '0;
        r2        = '0;
        start     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_bit",   32'(out_bit),   32'd0);
        check_output("rst_busy",      32'(busy),      32'd0);
        check_output("rst_cfg_err",   32'(cfg_err),   32'd0);
        check_output("rst_x",         32'(x_state),   32'd0);
        check_output("rst_y",         32'(y_state),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic iteration followed by a back-to-back one with y wrapping.
        apply_seed(8'd1, 8'd3, 8'd1, 8'd5, 3'd2, 3'd3, 1'b0);
        @(negedge clk);
        check_output("seed_cfg_err", 32'(cfg_err), 32'd0);
        check_output("seed_x",       32'(x_state), 32'd1);
        check_output("seed_y",       32'(y_state), 32'd3);
        exp_q.push_back('{x: 8'd6,  y: 8'd32, b: 1'b0});
        exp_q.push_back('{x: 8'd31, y: 8'd37, b: 1'b0});
        @(posedge clk);
        #1;
        start     = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_output("lat_out_valid", 32'(out_valid), 32'd1);
        check_output("lat_x",         32'(x_state),   32'd6);
        check_output("lat_y",         32'(y_state),   32'd32);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("b2b_idle_busy",  32'(busy),      32'd0);
        check_output("b2b_idle_valid", 32'(out_valid), 32'd0);
        if (pop_cycles.size() == 2) begin
            check_output("b2b_gap", 32'(pop_cycles[1] - pop_cycles[0]), 32'd6);
        end else begin
            check_output("b2b_pop_count", 32'(pop_cycles.size()), 32'd2);
        end

        // Wrap with x > y, held under backpressure.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        apply_seed(8'd200, 8'd10, 8'd1, 8'd1, 3'd2, 3'd2, 1'b0);
        @(negedge clk);
        check_output("wrap_cfg_err", 32'(cfg_err), 32'd0);
        exp_q.push_back('{x: 8'd233, y: 8'd51, b: 1'b1});
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid("wrap_valid_timeout", 20);

        // A seed_load while busy must leave everything untouched.
        @(posedge clk);
        #1;
        seed_load = 1'b1;
        x_seed    = 8'd99;
        y_seed    = 8'd98;
        b1        = 8'd4;
        b2        = 8'd4;
        r1        = 3'd1;
        r2        = 3'd0;
        @(posedge clk);
        #1;
        seed_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_output("bp_out_valid", 32'(out_valid), 32'd1);
            check_output("bp_out_bit",   32'(out_bit),   32'd1);
            check_output("bp_x",         32'(x_state),   32'd233);
            check_output("bp_y",         32'(y_state),   32'd51);
        end
        check_output("busy_load_cfg_err", 32'(cfg_err), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_output("bp_release_busy",  32'(busy),      32'd0);
        check_output("bp_release_valid", 32'(out_valid), 32'd0);

        // Next iteration uses the original shadow configuration.
        exp_q.push_back('{x: 8'd142, y: 8'd0, b: 1'b1});
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid("shadow_valid_timeout", 20);
        @(posedge clk);
        @(negedge clk);
        check_output("shadow_idle_busy", 32'(busy), 32'd0);

        // Non-full-period configuration, then load and start together.
        apply_seed(8'd3, 8'd3, 8'd1, 8'd4, 3'd1, 3'd2, 1'b0);
        @(negedge clk);
        check_output("bad_cfg_err", 32'(cfg_err), 32'd1);
        check_output("bad_busy",    32'(busy),    32'd0);
        apply_seed(8'd5, 8'd7, 8'd3, 8'd3, 3'd2, 3'd2, 1'b1);
        @(negedge clk);
        check_output("load_start_busy",    32'(busy),    32'd0);
        check_output("load_start_cfg_err", 32'(cfg_err), 32'd0);
        check_output("load_start_x",       32'(x_state), 32'd5);
        check_output("load_start_y",       32'(y_state), 32'd7);

        // Reset while in YS: x was already updated, all of it must vanish.
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("mid_x",    32'(x_state), 32'd28);
        check_output("mid_busy", 32'(busy),    32'd1);
        rst = 1'b1;
        #1;
        check_output("abort_out_valid", 32'(out_valid), 32'd0);
        check_output("abort_busy",      32'(busy),      32'd0);
        check_output("abort_x",         32'(x_state),   32'd0);
        check_output("abort_y",         32'(y_state),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("post_abort_busy",  32'(busy),      32'd0);
        check_output("post_abort_valid", 32'(out_valid), 32'd0);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
